// File: rtl/wat_rmw_ctrl_pkg.sv
// Shared definitions for the WAT read-modify-write controller:
// opcodes, FSM states and the packed layout of a WAT context entry.
package wat_rmw_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_FIRST  = 2'd0,
        OP_MIDDLE = 2'd1,
        OP_LAST   = 2'd2,
        OP_ONLY   = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_READ = 3'd2,
        ST_EXEC = 3'd3,
        ST_RSP  = 3'd4
    } state_t;

    localparam int ENTRY_W  = 128;
    localparam int VA_LSB   = 0;
    localparam int VA_W     = 64;
    localparam int RKEY_LSB = 64;
    localparam int RKEY_W   = 32;
    localparam int REM_LSB  = 96;
    localparam int REM_W    = 31;
    localparam int VLD_BIT  = 127;

    typedef struct packed {
        logic              vld;
        logic [REM_W-1:0]  rem;
        logic [RKEY_W-1:0] rkey;
        logic [VA_W-1:0]   va;
    } entry_t;

    function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
        entry_t e;
        e.vld  = raw[VLD_BIT];
        e.rem  = raw[REM_LSB +: REM_W];
        e.rkey = raw[RKEY_LSB +: RKEY_W];
        e.va   = raw[VA_LSB +: VA_W];
        return e;
    endfunction

    // Builds an open (valid) context entry.
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [REM_W-1:0]  rem,
                                                      input logic [RKEY_W-1:0] rkey,
                                                      input logic [VA_W-1:0]   va);
        logic [ENTRY_W-1:0] raw;
        raw                      = '0;
        raw[VLD_BIT]             = 1'b1;
        raw[REM_LSB +: REM_W]    = rem;
        raw[RKEY_LSB +: RKEY_W]  = rkey;
        raw[VA_LSB +: VA_W]      = va;
        return raw;
    endfunction

endpackage

// File: rtl/wat_rmw_ctrl.sv
// Per-QP RDMA WRITE context tracker: reads/updates the WAT entry for each packet
// and returns the target VA/rkey. Sweeps the table to zero after every reset.
module wat_rmw_ctrl
    import wat_rmw_ctrl_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        iv_req_op,
    input  logic [ADDR_W-1:0] iv_req_qpn,
    input  logic [63:0]       iv_req_va,
    input  logic [31:0]       iv_req_rkey,
    input  logic [31:0]       iv_req_dma_len,
    input  logic [15:0]       iv_req_pkt_len,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [63:0]       ov_rsp_va,
    output logic [31:0]       ov_rsp_rkey,
    output logic              o_rsp_err,
    output logic              o_wat_wr_en,
    output logic [127:0]      ov_wat_wr_data,
    output logic [ADDR_W-1:0] ov_wat_addra,
    output logic [ADDR_W-1:0] ov_wat_addrb,
    input  logic [127:0]      iv_wat_rd_data
);

    state_t            state;
    logic [ADDR_W:0]   init_cnt;
    op_t               req_op;
    logic [ADDR_W-1:0] req_qpn;
    logic [63:0]       req_va;
    logic [31:0]       req_rkey;
    logic [31:0]       req_dma;
    logic [15:0]       req_pkt;

    entry_t            ent;
    logic [30:0]       pkt31;
    logic [63:0]       pkt64;
    logic              dma_ok;
    logic              x_err;
    logic              x_we;
    logic [127:0]      x_wdata;
    logic [63:0]       x_va;
    logic [31:0]       x_rkey;

    // Result of the EXEC step; any error leaves x_wdata at zero, closing the context.
    always_comb begin
        ent     = unpack_entry(iv_wat_rd_data);
        pkt31   = {15'd0, req_pkt};
        pkt64   = {48'd0, req_pkt};
        dma_ok  = !req_dma[31];
        x_err   = 1'b0;
        x_we    = 1'b1;
        x_wdata = '0;
        x_va    = '0;
        x_rkey  = '0;
        case (req_op)
            OP_FIRST: begin
                if (!dma_ok || pkt31 > req_dma[30:0]) begin
                    x_err = 1'b1;
                end else begin
                    x_va    = req_va;
                    x_rkey  = req_rkey;
                    x_wdata = pack_entry(req_dma[30:0] - pkt31, req_rkey, req_va + pkt64);
                end
            end
            OP_MIDDLE: begin
                if (!ent.vld || pkt31 >= ent.rem) begin
                    x_err = 1'b1;
                end else begin
                    x_va    = ent.va;
                    x_rkey  = ent.rkey;
                    x_wdata = pack_entry(ent.rem - pkt31, ent.rkey, ent.va + pkt64);
                end
            end
            OP_LAST: begin
                if (!ent.vld || pkt31 != ent.rem) begin
                    x_err = 1'b1;
                end else begin
                    x_va   = ent.va;
                    x_rkey = ent.rkey;
                end
            end
            default: begin
                x_we   = 1'b0;
                x_err  = !dma_ok || pkt31 != req_dma[30:0];
                x_va   = req_va;
                x_rkey = req_rkey;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_INIT;
            init_cnt       <= '0;
            o_req_ready    <= 1'b0;
            o_rsp_valid    <= 1'b0;
            o_rsp_err      <= 1'b0;
            ov_rsp_va      <= '0;
            ov_rsp_rkey    <= '0;
            o_wat_wr_en    <= 1'b0;
            ov_wat_wr_data <= '0;
            ov_wat_addra   <= '0;
            ov_wat_addrb   <= '0;
        end else begin
            o_wat_wr_en <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (init_cnt[ADDR_W]) begin
                        o_req_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        o_wat_wr_en    <= 1'b1;
                        ov_wat_addra   <= init_cnt[ADDR_W-1:0];
                        ov_wat_wr_data <= '0;
                        init_cnt       <= init_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (i_req_valid && o_req_ready) begin
                        o_req_ready <= 1'b0;
                        req_op      <= op_t'(iv_req_op);
                        req_qpn     <= iv_req_qpn;
                        req_va      <= iv_req_va;
                        req_rkey    <= iv_req_rkey;
                        req_dma     <= iv_req_dma_len;
                        req_pkt     <= iv_req_pkt_len;
                        // Continuation packets need the stored context first.
                        if (op_t'(iv_req_op) == OP_MIDDLE || op_t'(iv_req_op) == OP_LAST) begin
                            ov_wat_addrb <= iv_req_qpn;
                            state        <= ST_READ;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_READ: state <= ST_EXEC;
                ST_EXEC: begin
                    o_wat_wr_en    <= x_we;
                    ov_wat_addra   <= req_qpn;
                    ov_wat_wr_data <= x_wdata;
                    ov_rsp_va      <= x_va;
                    ov_rsp_rkey    <= x_rkey;
                    o_rsp_err      <= x_err;
                    o_rsp_valid    <= 1'b1;
                    state          <= ST_RSP;
                end
                ST_RSP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_wat_rmw_ctrl.sv
// Self-checking bench for wat_rmw_ctrl with a 16-entry WAT RAM model and a
// per-QP context reference model.
module tb_wat_rmw_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = '0;
    logic [AW-1:0] req_qpn = '0;
    logic [63:0]   req_va = '0;
    logic [31:0]   req_rkey = '0;
    logic [31:0]   req_dma = '0;
    logic [15:0]   req_pkt = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [63:0]   rsp_va;
    logic [31:0]   rsp_rkey;
    logic          rsp_err;
    logic          wr_en;
    logic [127:0]  wr_data;
    logic [AW-1:0] addra;
    logic [AW-1:0] addrb;
    logic [127:0]  rd_data;

    logic [127:0]  mem [DEPTH];
    int            wr_total = 0;
    int            total = 0;
    int            bad = 0;

    bit            m_vld  [DEPTH];
    longint        m_rem  [DEPTH];
    logic [31:0]   m_rkey [DEPTH];
    logic [63:0]   m_va   [DEPTH];

    wat_rmw_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .iv_req_op(req_op), .iv_req_qpn(req_qpn), .iv_req_va(req_va),
        .iv_req_rkey(req_rkey), .iv_req_dma_len(req_dma), .iv_req_pkt_len(req_pkt),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .ov_rsp_va(rsp_va), .ov_rsp_rkey(rsp_rkey), .o_rsp_err(rsp_err),
        .o_wat_wr_en(wr_en), .ov_wat_wr_data(wr_data),
        .ov_wat_addra(addra), .ov_wat_addrb(addrb), .iv_wat_rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) mem[addra] <= wr_data;
        rd_data <= mem[addrb];
    end

    always @(negedge clk) if (wr_en) wr_total++;

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear(input int q);
        m_vld[q] = 1'b0; m_rem[q] = 0; m_rkey[q] = '0; m_va[q] = '0;
    endfunction

    function automatic logic [127:0] model_entry(input int q);
        logic [30:0] rem;
        rem = 31'(m_rem[q]);
        return {m_vld[q], rem, m_rkey[q], m_va[q]};
    endfunction

    // Context rules stated directly in terms of per-QP state.
    function automatic void model(input logic [1:0] op, input int q, input logic [63:0] va,
                                  input logic [31:0] rkey, input longint dma, input longint pkt,
                                  output logic [63:0] e_va, output logic [31:0] e_rkey,
                                  output logic e_err, output int e_wr);
        e_va = '0; e_rkey = '0; e_err = 1'b0; e_wr = 1;
        case (op)
            2'd0: if (pkt > dma) begin
                      e_err = 1'b1; model_clear(q);
                  end else begin
                      e_va = va; e_rkey = rkey;
                      m_vld[q] = 1'b1; m_rem[q] = dma - pkt; m_rkey[q] = rkey; m_va[q] = va + 64'(pkt);
                  end
            2'd1: if (!m_vld[q] || pkt >= m_rem[q]) begin
                      e_err = 1'b1; model_clear(q);
                  end else begin
                      e_va = m_va[q]; e_rkey = m_rkey[q];
                      m_rem[q] = m_rem[q] - pkt; m_va[q] = m_va[q] + 64'(pkt);
                  end
            2'd2: if (!m_vld[q] || pkt != m_rem[q]) begin
                      e_err = 1'b1; model_clear(q);
                  end else begin
                      e_va = m_va[q]; e_rkey = m_rkey[q]; model_clear(q);
                  end
            default: begin
                e_wr = 0; e_err = (pkt != dma); e_va = va; e_rkey = rkey;
            end
        endcase
    endfunction

    task automatic init_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            chk("init_wr_en", wr_en, 1);
            chk("init_addra", addra, i);
            chk("init_data", wr_data, 0);
            chk("init_ready_low", req_ready, 0);
            chk("init_rsp_valid", rsp_valid, 0);
        end
        @(posedge clk); #1;
        chk("init_done_wr_en", wr_en, 0);
        chk("init_done_ready", req_ready, 1);
    endtask

    task automatic do_req(input logic [1:0] op, input logic [AW-1:0] q, input logic [63:0] va,
                          input logic [31:0] rkey, input logic [31:0] dma, input logic [15:0] pkt,
                          input int hold);
        logic [63:0] e_va;
        logic [31:0] e_rkey;
        logic        e_err;
        int          e_wr;
        int          lat;
        int          wr0;
        int          exp_lat;
        model(op, int'(q), va, rkey, longint'(dma), longint'(pkt), e_va, e_rkey, e_err, e_wr);
        exp_lat = (op == 2'd1 || op == 2'd2) ? 3 : 2;
        req_valid = 1'b1; req_op = op; req_qpn = q; req_va = va;
        req_rkey = rkey; req_dma = dma; req_pkt = pkt;
        chk("req_ready", req_ready, 1);
        wr0 = wr_total;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_va", rsp_va, e_va);
        chk("rsp_rkey", rsp_rkey, e_rkey);
        chk("rsp_err", rsp_err, e_err);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_va", rsp_va, e_va);
            chk("hold_rkey", rsp_rkey, e_rkey);
            chk("hold_err", rsp_err, e_err);
            chk("hold_ready_low", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_released", rsp_valid, 0);
        chk("ready_again", req_ready, 1);
        chk("wat_writes", wr_total - wr0, e_wr);
        chk("wat_entry", mem[q], model_entry(int'(q)));
    endtask

    initial begin
        logic [1:0]    op;
        logic [AW-1:0] q;
        logic [63:0]   va;
        logic [31:0]   rkey;
        logic [31:0]   dma;
        logic [15:0]   pkt;
        for (int i = 0; i < DEPTH; i++) model_clear(i);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_va", rsp_va, 0);
        chk("rst_rsp_rkey", rsp_rkey, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_addra", addra, 0);
        chk("rst_addrb", addrb, 0);
        rst = 1'b0;
        init_sweep();

        do_req(2'd0, 4'd3, 64'h1000, 32'hAB, 32'd4096, 16'd1024, 0);
        chk("first_entry_const", mem[3], {1'b1, 31'd3072, 32'hAB, 64'h1400});
        do_req(2'd1, 4'd3, 64'h0, 32'h0, 32'd0, 16'd1024, 1);
        chk("mid1_va_const", rsp_va, 64'h1400);
        do_req(2'd1, 4'd3, 64'h0, 32'h0, 32'd0, 16'd1024, 0);
        chk("mid2_va_const", rsp_va, 64'h1800);
        do_req(2'd2, 4'd3, 64'h0, 32'h0, 32'd0, 16'd1024, 0);
        chk("last_va_const", rsp_va, 64'h1C00);
        chk("last_entry_zero", mem[3], 0);

        do_req(2'd0, 4'd3, 64'h4000, 32'h55, 32'd2048, 16'd1024, 0);
        do_req(2'd2, 4'd3, 64'h0, 32'h0, 32'd0, 16'd512, 0);
        chk("last_short_err", rsp_err, 1);
        do_req(2'd1, 4'd3, 64'h0, 32'h0, 32'd0, 16'd128, 0);
        chk("mid_invalid_err", rsp_err, 1);

        do_req(2'd3, 4'd9, 64'h2000, 32'h77, 32'd256, 16'd256, 5);
        do_req(2'd0, 4'd2, 64'h9000, 32'h11, 32'd100, 16'd200, 0);

        do_req(2'd0, 4'd5, 64'hFFFF_FFFF_FFFF_FC00, 32'hC0DE, 32'd2048, 16'd1024, 0);
        chk("wrap_entry_va", mem[5][63:0], 64'h0);
        do_req(2'd1, 4'd5, 64'h0, 32'h0, 32'd0, 16'd512, 0);
        do_req(2'd0, 4'd5, 64'h7000, 32'hBEEF, 32'd900, 16'd100, 0);

        // Reset while a continuation packet is in its read wait cycle.
        do_req(2'd0, 4'd7, 64'h5000, 32'h99, 32'd1000, 16'd200, 0);
        req_valid = 1'b1; req_op = 2'd1; req_qpn = 4'd7; req_pkt = 16'd100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_wr_en", wr_en, 0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_clear(i);
        init_sweep();
        chk("midrst_entry_cleared", mem[7], 0);

        for (int n = 0; n < 60; n++) begin
            op   = 2'($urandom_range(0, 3));
            q    = AW'($urandom_range(0, DEPTH - 1));
            va   = {$urandom, $urandom};
            rkey = $urandom;
            dma  = 32'($urandom_range(0, 5000));
            pkt  = ($urandom_range(0, 1) == 1) ? 16'(dma) : 16'($urandom_range(0, 5000));
            if ((op == 2'd1 || op == 2'd2) && m_vld[q] && $urandom_range(0, 3) != 0)
                pkt = (op == 2'd2) ? 16'(m_rem[q]) : 16'(m_rem[q] / 2);
            do_req(op, q, va, rkey, dma, pkt, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
